// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS execute-stage units.
package mips_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    // Divide-by-zero LO result; wide enough for any supported WIDTH, truncated at use.
    localparam logic [63:0] DIV0_LO = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: gives |x| when negate is the operand sign,
// or applies a result sign when negate is the sign rule.
module muldiv_abs #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result_c
);

    assign result_c = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with two-lane issue arbitration and
// architectural HI/LO; one operand bit per cycle, signs applied in a final FIX cycle.
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start0E,
    input  logic             start1E,
    input  logic             div0E,
    input  logic             div1E,
    input  logic             sgn0E,
    input  logic             sgn1E,
    input  logic [WIDTH-1:0] srca0E,
    input  logic [WIDTH-1:0] srcb0E,
    input  logic [WIDTH-1:0] srca1E,
    input  logic [WIDTH-1:0] srcb1E,
    input  logic             cancelE,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             start_multE,
    output logic             busy_multE,
    output logic             reject1E,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, stateNext;
    logic             accept;
    logic [CW-1:0]    cnt;
    logic             opDiv, negA, negB, divZero;
    logic [WIDTH-1:0] opnd, rawA;
    logic [W2-1:0]    acc, accNext;

    // Lane 0 is older in program order, so it wins a same-cycle issue
    logic             selDiv, selSgn, selNegA, selNegB;
    logic [WIDTH-1:0] selA, selB, magA, magB;

    assign selDiv  = start0E ? div0E  : div1E;
    assign selSgn  = start0E ? sgn0E  : sgn1E;
    assign selA    = start0E ? srca0E : srca1E;
    assign selB    = start0E ? srcb0E : srcb1E;
    assign selNegA = selSgn & selA[WIDTH-1];
    assign selNegB = selSgn & selB[WIDTH-1];

    muldiv_abs #(.W(WIDTH)) uAbsA (.value(selA), .negate(selNegA), .result_c(magA));
    muldiv_abs #(.W(WIDTH)) uAbsB (.value(selB), .negate(selNegB), .result_c(magB));

    always_comb begin
        stateNext   = state;
        accept      = 1'b0;
        start_multE = 1'b0;
        reject1E    = 1'b0;
        case (state)
            IDLE: begin
                accept      = start0E | start1E;
                start_multE = accept;
                reject1E    = start0E & start1E;
                if (accept) stateNext = RUN;
            end
            RUN: begin
                if (cancelE)          stateNext = IDLE;
                else if (cnt == LAST) stateNext = FIX;
            end
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // One shift-add step (multiply) or one restoring step (divide) per RUN cycle
    logic [WIDTH:0] mulSum, remShift;
    logic           remFits;

    always_comb begin
        mulSum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        remShift = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        remFits  = remShift >= {1'b0, opnd};
        if (opDiv) begin
            if (remFits) accNext = {WIDTH'(remShift - {1'b0, opnd}), acc[WIDTH-2:0], 1'b1};
            else         accNext = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end
    end

    logic [W2-1:0]    prodS;
    logic [WIDTH-1:0] quoS, remS, hiFix, loFix;

    muldiv_abs #(.W(W2))    uFixProd (.value(acc),              .negate(negA ^ negB), .result_c(prodS));
    muldiv_abs #(.W(WIDTH)) uFixQuo  (.value(acc[WIDTH-1:0]),   .negate(negA ^ negB), .result_c(quoS));
    muldiv_abs #(.W(WIDTH)) uFixRem  (.value(acc[W2-1:WIDTH]),  .negate(negA),        .result_c(remS));

    always_comb begin
        hiFix = prodS[W2-1:WIDTH];
        loFix = prodS[WIDTH-1:0];
        if (opDiv) begin
            hiFix = divZero ? rawA : remS;
            loFix = divZero ? WIDTH'(DIV0_LO) : quoS;
        end
    end

    // Multiply seeds acc with |b| and adds |a|; divide seeds acc with |a| and trials |b|
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            opDiv      <= 1'b0;
            negA       <= 1'b0;
            negB       <= 1'b0;
            divZero    <= 1'b0;
            opnd       <= '0;
            rawA       <= '0;
            acc        <= '0;
            hi         <= '0;
            lo         <= '0;
            busy_multE <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy_multE <= (stateNext != IDLE);
            done       <= (state == FIX) && !cancelE;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        cnt     <= '0;
                        opDiv   <= selDiv;
                        negA    <= selNegA;
                        negB    <= selNegB;
                        divZero <= (selB == '0);
                        rawA    <= selA;
                        opnd    <= selDiv ? magB : magA;
                        acc     <= {WIDTH'(0), (selDiv ? magA : magB)};
                    end
                end
                RUN: begin
                    acc <= accNext;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (!cancelE) begin
                        hi <= hiFix;
                        lo <= loFix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, arbitration, cancel,
// reset and MTHI corner cases, plus random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0E, start1E, div0E, div1E, sgn0E, sgn1E;
    logic [31:0] srca0E, srcb0E, srca1E, srcb1E;
    logic        cancelE, hi_we, lo_we;
    logic [31:0] wdata;
    logic        start_multE, busy_multE, reject1E, done;
    logic [31:0] hi, lo;

    int nCmp = 0;
    int nErr = 0;

    int          obsBusy, obsDone;
    logic        obsStart, obsRej;
    logic [31:0] obsHi, obsLo;
    logic        pkStart, pkRej, pkBusy, pkDone;
    logic [31:0] pkHi, pkLo;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .start0E(start0E), .start1E(start1E), .div0E(div0E), .div1E(div1E),
        .sgn0E(sgn0E), .sgn1E(sgn1E),
        .srca0E(srca0E), .srcb0E(srcb0E), .srca1E(srca1E), .srcb1E(srcb1E),
        .cancelE(cancelE), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .start_multE(start_multE), .busy_multE(busy_multE), .reject1E(reject1E),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Architectural result {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] refModel(input bit isDiv, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] up;
        if (!isDiv) begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            up = {32'b0, a} * {32'b0, b};
            return up;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            return {32'(sr), 32'(sq)};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and follow it; pokeKind 1=lane1 start, 2=cancel, 3=MTHI/MTLO, 4=reset
    task automatic execOp(input bit st0, input bit st1,
                          input bit d0, input bit g0, input logic [31:0] a0, input logic [31:0] b0,
                          input bit d1, input bit g1, input logic [31:0] a1, input logic [31:0] b1,
                          input bit immediate, input int pokeCyc, input int pokeKind);
        if (!immediate) @(negedge clk);
        start0E = st0; div0E = d0; sgn0E = g0; srca0E = a0; srcb0E = b0;
        start1E = st1; div1E = d1; sgn1E = g1; srca1E = a1; srcb1E = b1;
        #1;
        obsStart = start_multE;
        obsRej   = reject1E;
        @(negedge clk);
        start0E = 1'b0;
        start1E = 1'b0;
        obsBusy = 0;
        obsDone = -1;
        {pkStart, pkRej, pkBusy, pkDone} = '0;
        pkHi = '0;
        pkLo = '0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (busy_multE) obsBusy++;
            if (done) begin
                obsDone = cyc;
                break;
            end
            if (cyc == pokeCyc) begin
                case (pokeKind)
                    1: begin
                        start1E = 1'b1; div1E = 1'($urandom_range(1)); sgn1E = 1'($urandom_range(1));
                        srca1E = $urandom; srcb1E = $urandom;
                    end
                    2: cancelE = 1'b1;
                    3: begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
                    4: reset = 1'b0;
                    default: ;
                endcase
                #1;
                pkStart = start_multE; pkRej = reject1E; pkBusy = busy_multE;
                pkDone = done; pkHi = hi; pkLo = lo;
            end
            @(negedge clk);
            start1E = 1'b0; cancelE = 1'b0; hi_we = 1'b0; lo_we = 1'b0; reset = 1'b1;
        end
        obsHi = hi;
        obsLo = lo;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {start0E, start1E, div0E, div1E, sgn0E, sgn1E, cancelE, hi_we, lo_we} = '0;
        {srca0E, srcb0E, srca1E, srcb1E, wdata} = '0;
        repeat (3) @(negedge clk);
        nCmp++; if (hi !== 32'h0) begin nErr++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        nCmp++; if (lo !== 32'h0) begin nErr++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        nCmp++; if (busy_multE !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b expected 0", busy_multE); end
        nCmp++; if (done !== 1'b0) begin nErr++; $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b1;
        @(negedge clk);
        nCmp++; if (start_multE !== 1'b0 || reject1E !== 1'b0) begin
            nErr++; $display("FAIL idle_no_start: start_multE=%b reject1E=%b expected 0 0", start_multE, reject1E);
        end
    endtask

    task automatic test_directed();
        bit          dv[6] = '{0, 0, 0, 1, 1, 1};
        bit          sg[6] = '{0, 1, 1, 0, 1, 1};
        logic [31:0] ta[6] = '{32'd7, 32'hFFFF_FFFD, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9, 32'd5};
        logic [31:0] tb[6] = '{32'd6, 32'd5, 32'h8000_0000, 32'd7, 32'd2, 32'd0};
        logic [31:0] eh[6] = '{32'd0, 32'hFFFF_FFFF, 32'h4000_0000, 32'd2, 32'hFFFF_FFFF, 32'd5};
        logic [31:0] el[6] = '{32'd42, 32'hFFFF_FFF1, 32'h0, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            execOp(1, 0, dv[i], sg[i], ta[i], tb[i], 0, 0, 0, 0, 0, 0, 0);
            nCmp++; if (obsStart !== 1'b1 || obsRej !== 1'b0) begin
                nErr++; $display("FAIL directed%0d_issue: start=%b reject=%b expected 1 0", i, obsStart, obsRej);
            end
            nCmp++; if (obsBusy != 33) begin nErr++; $display("FAIL directed%0d_busy_cycles: got %0d expected 33", i, obsBusy); end
            nCmp++; if (obsDone != 34) begin nErr++; $display("FAIL directed%0d_done_cycle: got %0d expected 34", i, obsDone); end
            nCmp++; if (obsHi !== eh[i]) begin nErr++; $display("FAIL directed%0d_hi: got %h expected %h", i, obsHi, eh[i]); end
            nCmp++; if (obsLo !== el[i]) begin nErr++; $display("FAIL directed%0d_lo: got %h expected %h", i, obsLo, el[i]); end
        end
    endtask

    task automatic test_mthi_mtlo_idle();
        logic [31:0] v1, v2, oldLo;
        v1 = $urandom; v2 = $urandom; oldLo = lo;
        @(negedge clk); hi_we = 1'b1; wdata = v1;
        @(negedge clk); hi_we = 1'b0;
        nCmp++; if (hi !== v1 || lo !== oldLo) begin
            nErr++; $display("FAIL mthi_idle: hi=%h lo=%h expected %h %h", hi, lo, v1, oldLo);
        end
        lo_we = 1'b1; wdata = v2;
        @(negedge clk); lo_we = 1'b0;
        nCmp++; if (lo !== v2 || hi !== v1) begin
            nErr++; $display("FAIL mtlo_idle: hi=%h lo=%h expected %h %h", hi, lo, v1, v2);
        end
    endtask

    task automatic test_dual_issue();
        logic [31:0] a0, b0, a1, b1;
        logic [63:0] exp;
        a0 = randOperand(); b0 = randOperand(); a1 = $urandom; b1 = $urandom;
        exp = refModel(0, 1, a0, b0);
        execOp(1, 1, 0, 1, a0, b0, 1, 0, a1, b1, 0, 0, 0);
        nCmp++; if (obsRej !== 1'b1 || obsStart !== 1'b1) begin
            nErr++; $display("FAIL dual_reject: start=%b reject=%b expected 1 1", obsStart, obsRej);
        end
        nCmp++; if ({obsHi, obsLo} !== exp) begin
            nErr++; $display("FAIL dual_lane0_result: got %h expected %h", {obsHi, obsLo}, exp);
        end
        a1 = randOperand(); b1 = randOperand();
        exp = refModel(1, 0, a1, b1);
        execOp(0, 1, 0, 0, a0, b0, 1, 0, a1, b1, 0, 0, 0);
        nCmp++; if (obsRej !== 1'b0 || obsStart !== 1'b1) begin
            nErr++; $display("FAIL lane1_alone_issue: start=%b reject=%b expected 1 0", obsStart, obsRej);
        end
        nCmp++; if ({obsHi, obsLo} !== exp) begin
            nErr++; $display("FAIL lane1_alone_result: got %h expected %h", {obsHi, obsLo}, exp);
        end
    endtask

    task automatic test_start_in_run();
        logic [31:0] a, b;
        logic [63:0] exp;
        a = randOperand(); b = randOperand();
        exp = refModel(1, 1, a, b);
        execOp(1, 0, 1, 1, a, b, 0, 0, 0, 0, 0, 5, 1);
        nCmp++; if (pkStart !== 1'b0 || pkRej !== 1'b0) begin
            nErr++; $display("FAIL run_start_ignored: start=%b reject=%b expected 0 0", pkStart, pkRej);
        end
        nCmp++; if (obsBusy != 33 || obsDone != 34) begin
            nErr++; $display("FAIL run_start_timing: busy=%0d done=%0d expected 33 34", obsBusy, obsDone);
        end
        nCmp++; if ({obsHi, obsLo} !== exp) begin
            nErr++; $display("FAIL run_start_result: got %h expected %h", {obsHi, obsLo}, exp);
        end
    endtask

    task automatic test_cancel();
        logic [31:0] priorHi, priorLo;
        priorHi = hi; priorLo = lo;
        execOp(1, 0, 0, 0, $urandom, $urandom, 0, 0, 0, 0, 0, 10, 2);
        nCmp++; if (obsDone != -1) begin nErr++; $display("FAIL cancel_no_done: done cycle %0d expected none", obsDone); end
        nCmp++; if (obsBusy != 10) begin nErr++; $display("FAIL cancel_busy_cycles: got %0d expected 10", obsBusy); end
        nCmp++; if (obsHi !== priorHi || obsLo !== priorLo) begin
            nErr++; $display("FAIL cancel_hilo_kept: got %h %h expected %h %h", obsHi, obsLo, priorHi, priorLo);
        end
    endtask

    task automatic test_mthi_in_run();
        logic [31:0] priorHi, a, b;
        logic [63:0] exp;
        priorHi = hi; a = randOperand(); b = randOperand();
        exp = refModel(0, 0, a, b);
        execOp(1, 0, 0, 0, a, b, 0, 0, 0, 0, 0, 5, 3);
        nCmp++; if (pkHi !== priorHi) begin nErr++; $display("FAIL mthi_run_ignored: got %h expected %h", pkHi, priorHi); end
        nCmp++; if ({obsHi, obsLo} !== exp) begin
            nErr++; $display("FAIL mthi_run_result: got %h expected %h", {obsHi, obsLo}, exp);
        end
    endtask

    task automatic test_reset_mid_run();
        execOp(1, 0, 1, 0, $urandom, 32'd3, 0, 0, 0, 0, 0, 10, 4);
        nCmp++; if ({pkBusy, pkDone} !== 2'b00 || pkHi !== 32'h0 || pkLo !== 32'h0) begin
            nErr++; $display("FAIL reset_mid_run_outputs: busy=%b done=%b hi=%h lo=%h expected all 0", pkBusy, pkDone, pkHi, pkLo);
        end
        nCmp++; if (obsDone != -1 || obsBusy != 10) begin
            nErr++; $display("FAIL reset_mid_run_after: done=%0d busy=%0d expected -1 10", obsDone, obsBusy);
        end
        nCmp++; if (obsHi !== 32'h0 || obsLo !== 32'h0) begin
            nErr++; $display("FAIL reset_mid_run_hilo: got %h %h expected 0 0", obsHi, obsLo);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            bit dv, sg;
            logic [63:0] exp;
            a = randOperand(); b = randOperand();
            dv = 1'(i & 1); sg = 1'(i >> 1);
            exp = refModel(dv, sg, a, b);
            execOp(1, 0, dv, sg, a, b, 0, 0, 0, 0, (i != 0), 0, 0);
            nCmp++; if (obsStart !== 1'b1 || obsDone != 34) begin
                nErr++; $display("FAIL b2b%0d_accept: start=%b done=%0d expected 1 34", i, obsStart, obsDone);
            end
            nCmp++; if ({obsHi, obsLo} !== exp) begin
                nErr++; $display("FAIL b2b%0d_result: got %h expected %h", i, {obsHi, obsLo}, exp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            bit dv, sg, lane1;
            logic [63:0] exp;
            a = randOperand(); b = randOperand();
            dv = 1'($urandom_range(1)); sg = 1'($urandom_range(1)); lane1 = 1'($urandom_range(1));
            exp = refModel(dv, sg, a, b);
            if (lane1) execOp(0, 1, 0, 0, 0, 0, dv, sg, a, b, 1'($urandom_range(1)), 0, 0);
            else       execOp(1, 0, dv, sg, a, b, 0, 0, 0, 0, 1'($urandom_range(1)), 0, 0);
            nCmp++; if (obsBusy != 33 || obsDone != 34) begin
                nErr++; $display("FAIL rand%0d_timing: busy=%0d done=%0d expected 33 34", i, obsBusy, obsDone);
            end
            nCmp++; if ({obsHi, obsLo} !== exp) begin
                nErr++; $display("FAIL rand%0d_result div=%b sgn=%b a=%h b=%h: got %h expected %h",
                                 i, dv, sg, a, b, {obsHi, obsLo}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo_idle();
        test_dual_issue();
        test_start_in_run();
        test_cancel();
        test_mthi_in_run();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
